// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display path: decoder character codes
// and the scan FSM state type.
package display_pkg;

    localparam logic [3:0] CHAR_DASH  = 4'd10;
    localparam logic [3:0] CHAR_BLANK = 4'd11;
    localparam logic [3:0] CHAR_F     = 4'd15;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_e;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Phase counter for the scan FSM: counts cycles in the current BLANK/ON phase
// and flags the last cycle of the phase, both now and one cycle ahead.
module scan_timer
    import display_pkg::*;
#(
    parameter int ON_CYCLES    = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic on_phase,
    output logic done,
    output logic done_next
);

    localparam int MAX_LEN = max_len(ON_CYCLES, BLANK_CYCLES);
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_d;
    logic          on_next;

    // done_next lets the parent register outputs that depend on the phase
    // position the FSM is about to enter.
    always_comb begin
        done      = (count == (on_phase ? ON_LAST : BLANK_LAST));
        count_d   = done ? '0 : count + CW'(1);
        on_next   = on_phase ^ done;
        done_next = (count_d == (on_next ? ON_LAST : BLANK_LAST));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: blank gap then ON slot per digit,
// with a one-deep frame buffer applied only at frame boundaries.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4*NUM_DIGITS-1:0]       frame_in,
    output logic [3:0]                    char_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    scan_state_e state;
    scan_state_e state_d;
    logic [IW-1:0] idx_d;

    logic [NUM_DIGITS-1:0][3:0] display;
    logic [NUM_DIGITS-1:0][3:0] display_d;
    logic [NUM_DIGITS-1:0][3:0] shadow;
    logic pending;
    logic pending_d;

    logic phase_done;
    logic phase_done_next;
    logic wrap;
    logic transfer;

    logic [NUM_DIGITS-1:0] anode_d;
    logic [3:0]            char_d;
    logic                  frame_done_d;

    scan_timer #(
        .ON_CYCLES    (ON_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clk       (clk),
        .reset     (reset),
        .on_phase  (state == ON),
        .done      (phase_done),
        .done_next (phase_done_next)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state;
        idx_d     = digit_idx;
        display_d = display;
        pending_d = pending;
        wrap      = 1'b0;
        transfer  = in_valid && in_ready;

        if (phase_done) begin
            if (state == BLANK) begin
                state_d = ON;
            end else begin
                state_d = BLANK;
                if (digit_idx == IDX_LAST) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = digit_idx + IW'(1);
                end
            end
        end

        // Transfer and apply are exclusive: in_ready is low whenever pending is set.
        if (transfer) begin
            pending_d = 1'b1;
        end
        if (wrap && pending) begin
            display_d = shadow;
            pending_d = 1'b0;
        end

        // Outputs are computed from next-state values so the registered
        // outputs line up with the state they describe.
        anode_d      = '1;
        char_d       = CHAR_BLANK;
        frame_done_d = 1'b0;
        if (state_d == ON) begin
            anode_d[idx_d] = 1'b0;
            char_d         = display_d[idx_d];
            frame_done_d   = (idx_d == IDX_LAST) && phase_done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            digit_idx  <= '0;
            display    <= {NUM_DIGITS{CHAR_BLANK}};
            pending    <= 1'b0;
            in_ready   <= 1'b1;
            anode_n    <= '1;
            char_out   <= CHAR_BLANK;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            digit_idx  <= idx_d;
            display    <= display_d;
            pending    <= pending_d;
            in_ready   <= !pending_d;
            anode_n    <= anode_d;
            char_out   <= char_d;
            frame_done <= frame_done_d;
        end
    end

    // NOTE: the shadow buffer is deliberately not reset; it is only ever read
    // while pending is set, and pending is cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && transfer) begin
            shadow <= frame_in;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: frame-level reference model feeds
// a per-cycle scoreboard that a negedge monitor drains and compares.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int ON_C  = 16;
    localparam int BL_C  = 2;
    localparam int SLOT  = ON_C + BL_C;
    localparam int FRAME = N * SLOT;
    localparam int FW    = 4 * N;

    typedef struct packed {
        logic [N-1:0] an;
        logic [3:0]   ch;
        logic [1:0]   idx;
        logic         fd;
        logic         rdy;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] frame_in;
    logic [3:0]    char_out;
    logic [N-1:0]  anode_n;
    logic [1:0]    digit_idx;
    logic          frame_done;

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    display_scan_ctrl #(
        .NUM_DIGITS   (N),
        .ON_CYCLES    (ON_C),
        .BLANK_CYCLES (BL_C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frame_in   (frame_in),
        .char_out   (char_out),
        .anode_n    (anode_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: position in the frame follows from elapsed cycles since
    // reset; a frame accepted earlier becomes visible at the next multiple of FRAME.
    initial begin : model
        int         t;
        int         p, d, q;
        logic [3:0] disp[N];
        logic       m_pend;
        logic [FW-1:0] m_shadow;
        bit         accept;
        obs_t       e;
        t = 0;
        m_pend = 1'b0;
        m_shadow = '0;
        for (int k = 0; k < N; k++) disp[k] = 4'd11;
        forever begin
            @(posedge clk);
            if (reset) begin
                t = 0;
                m_pend = 1'b0;
                for (int k = 0; k < N; k++) disp[k] = 4'd11;
            end else begin
                accept = in_valid && !m_pend;
                t++;
                if ((t % FRAME) == 0 && m_pend) begin
                    for (int k = 0; k < N; k++) disp[k] = m_shadow[4*k +: 4];
                    m_pend = 1'b0;
                end
                if (accept) begin
                    m_shadow = frame_in;
                    m_pend   = 1'b1;
                end
            end
            p = t % FRAME;
            d = p / SLOT;
            q = p % SLOT;
            e.an  = '1;
            e.ch  = 4'd11;
            e.idx = 2'(d);
            e.fd  = 1'b0;
            e.rdy = !m_pend;
            if (q >= BL_C) begin
                e.an[d] = 1'b0;
                e.ch    = disp[d];
                e.fd    = (d == N - 1) && (q == SLOT - 1);
            end
            sb.push_back(e);
        end
    end

    initial begin : monitor
        obs_t e;
        obs_t got;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard cyc %0d: got no expected entry, required one", cyc);
            end else begin
                e = sb.pop_front();
                got.an  = anode_n;
                got.ch  = char_out;
                got.idx = digit_idx;
                got.fd  = frame_done;
                got.rdy = in_ready;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs cyc %0d: got anode_n=%b char=%0d idx=%0d done=%b rdy=%b, required anode_n=%b char=%0d idx=%0d done=%b rdy=%b",
                             cyc, got.an, got.ch, got.idx, got.fd, got.rdy, e.an, e.ch, e.idx, e.fd, e.rdy);
                end
            end
            vectors++;
            if ($countones(~anode_n) > 1) begin
                miscompares++;
                $display("FAIL anode_onehot cyc %0d: got anode_n=%b, required at most one low bit", cyc, anode_n);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [FW-1:0] f);
        int   waited;
        logic got;
        waited   = 0;
        got      = 1'b0;
        in_valid = 1'b1;
        frame_in = f;
        while (!got) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #2;
            waited++;
            if (waited > 3 * FRAME) begin
                $display("FAIL handshake: in_ready stayed 0 for %0d cycles, required 1 within %0d", waited, 3 * FRAME);
                $fatal(1, "handshake stalled");
            end
        end
        in_valid = 1'b0;
        frame_in = FW'($urandom);
    endtask

    task automatic wait_on(input int dig);
        int n;
        n = 0;
        while (!(digit_idx == 2'(dig) && anode_n[dig] == 1'b0)) begin
            @(posedge clk);
            #2;
            n++;
            if (n > 2 * FRAME) begin
                $display("FAIL wait_on: digit %0d not driven within %0d cycles", dig, 2 * FRAME);
                $fatal(1, "scan stalled");
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    initial begin : stimulus
        reset    = 1'b1;
        in_valid = 1'b0;
        frame_in = '0;
        idle(2);
        reset = 1'b0;

        // Reset with no frame: blanks only for three frame periods.
        idle(3 * FRAME);

        // Mixed digits, dash and blank codes.
        send(16'h9A0B);
        idle(3 * FRAME);

        // Back-to-back frames: second waits until the first has been applied.
        send(16'h1111);
        send(16'h2222);
        idle(3 * FRAME);

        // Reset during digit 2 ON with a frame still pending.
        wait_on(0);
        send(16'h5678);
        wait_on(2);
        idle(3);
        pulse_reset();
        idle(2 * FRAME);

        // Codes above 9 pass straight through.
        send(16'hFEDC);
        idle(2 * FRAME);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 20; i++) begin
            idle($urandom_range(0, 90));
            if ($urandom_range(0, 6) == 0) pulse_reset();
            send(FW'($urandom));
        end
        idle(FRAME + 4);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
